// File: rtl/carwash_timers_if.sv
// carwash_timers_if -- bundle between carwash_fsm and carwash_timers.
//   CLRT1, CLRT2 : timer clear requests, driven by the FSM (master)
//   T1DONE, T2DONE : timer expiry flags, driven by the timer block (slave)
//   REMAIN1 : seconds left on timer 1, present only when CARWASH_REMAIN_EN
//             is defined (the CNT_W parameter exists only in that build)
interface carwash_timers_if
`ifdef CARWASH_REMAIN_EN
  #(parameter int CNT_W = 8)
`endif
  ;
  logic CLRT1;
  logic CLRT2;
  logic T1DONE;
  logic T2DONE;
`ifdef CARWASH_REMAIN_EN
  logic [CNT_W-1:0] REMAIN1;

  modport master (output CLRT1, CLRT2, input T1DONE, T2DONE, REMAIN1);
  modport slave  (input CLRT1, CLRT2, output T1DONE, T2DONE, REMAIN1);
`else
  modport master (output CLRT1, CLRT2, input T1DONE, T2DONE);
  modport slave  (input CLRT1, CLRT2, output T1DONE, T2DONE);
`endif
endinterface

// File: rtl/carwash_timers.sv
// carwash_timers -- two independent prescaled elapsed-time counters that
// serve carwash_fsm. Each timer counts whole "seconds" of TICK_DIV clock
// cycles after its clear request drops and raises its DONE flag once the
// programmed duration has elapsed, then holds until cleared again.
//
// Ports:
//   clk  : system clock, rising edge
//   clr  : asynchronous active-high reset
//   bus  : carwash_timers_if.slave
//            CLRT1/CLRT2   in  level-sensitive synchronous clears
//            T1DONE/T2DONE out registered expiry flags
//            REMAIN1       out seconds left on timer 1 (CARWASH_REMAIN_EN)
//
// Optional feature macro: CARWASH_REMAIN_EN adds the REMAIN1 countdown.
module carwash_timers #(
  parameter int TICK_DIV = 50_000_000,
  parameter int T1_SECS  = 30,
  parameter int T2_SECS  = 10,
  parameter int CNT_W    = 8
) (
  input logic clk,
  input logic clr,
  carwash_timers_if.slave bus
);

  // TICK_DIV=1 still needs a one-bit prescaler; it stays at zero because
  // every cycle is then the last tick of a second.
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  function automatic logic [CNT_W-1:0] sec_inc(input logic [CNT_W-1:0] s);
    return s + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] rem_dec(input logic [CNT_W-1:0] r);
    // Never wraps below zero; the done flag stops decrements first anyway.
    return (r == '0) ? '0 : r - CNT_W'(1);
  endfunction

  logic [1:0] clrt;
  logic [1:0] done;

  assign clrt = {bus.CLRT2, bus.CLRT1};

  for (genvar k = 0; k < 2; k++) begin : g_tmr
    localparam logic [CNT_W-1:0] SECS = CNT_W'((k == 0) ? T1_SECS : T2_SECS);

    logic [PRE_W-1:0] pre_p0;
    logic [CNT_W-1:0] sec_p0;
    logic             done_p0;
    logic             last_tick;

    assign last_tick = (pre_p0 == PRE_LAST);

    // Stage 0: prescaler, seconds counter and saturating done flag.
    // Clear beats counting, so a clear on the completing edge leaves done low.
    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        pre_p0  <= '0;
        sec_p0  <= '0;
        done_p0 <= 1'b0;
      end else if (clrt[k]) begin
        pre_p0  <= '0;
        sec_p0  <= '0;
        done_p0 <= 1'b0;
      end else if (!done_p0) begin
        if (last_tick) begin
          pre_p0  <= '0;
          sec_p0  <= sec_inc(sec_p0);
          done_p0 <= (sec_inc(sec_p0) == SECS);
        end else begin
          pre_p0  <= pre_p0 + PRE_W'(1);
        end
      end
    end

    assign done[k] = done_p0;
  end

  assign bus.T1DONE = done[0];
  assign bus.T2DONE = done[1];

`ifdef CARWASH_REMAIN_EN
  logic [CNT_W-1:0] remain_p0;

  // Stage 0: countdown kept in step with sec_1, so it equals T1_SECS - sec_1
  // as a register of its own and reaches zero on the edge T1DONE rises.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      remain_p0 <= CNT_W'(T1_SECS);
    end else if (clrt[0]) begin
      remain_p0 <= CNT_W'(T1_SECS);
    end else if (!done[0] && g_tmr[0].last_tick) begin
      remain_p0 <= rem_dec(remain_p0);
    end
  end

  assign bus.REMAIN1 = remain_p0;
`endif

endmodule

// File: tb/tb_carwash_timers.sv
// tb_carwash_timers -- bench for carwash_timers. Two instances: dut_a with
// TICK_DIV=4 and dut_b with TICK_DIV=1, both T1_SECS=3, T2_SECS=2. The
// reference model counts uncleared edges since the last clear or reset; a
// timer is done once that count reaches SECS*TICK_DIV.
module tb_carwash_timers;
  localparam int T1S   = 3;
  localparam int T2S   = 2;
  localparam int CW    = 8;
  localparam int DIV_A = 4;
  localparam int DIV_B = 1;

  logic clk = 1'b0;
  logic clr = 1'b1;

`ifdef CARWASH_REMAIN_EN
  carwash_timers_if #(.CNT_W(CW)) bus_a ();
  carwash_timers_if #(.CNT_W(CW)) bus_b ();
`else
  carwash_timers_if bus_a ();
  carwash_timers_if bus_b ();
`endif

  carwash_timers #(.TICK_DIV(DIV_A), .T1_SECS(T1S), .T2_SECS(T2S), .CNT_W(CW)) dut_a (
    .clk(clk), .clr(clr), .bus(bus_a.slave));
  carwash_timers #(.TICK_DIV(DIV_B), .T1_SECS(T1S), .T2_SECS(T2S), .CNT_W(CW)) dut_b (
    .clk(clk), .clr(clr), .bus(bus_b.slave));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: uncleared edges since last clear, saturating at limit.
  int ea1 = 0, ea2 = 0, eb1 = 0, eb2 = 0;

  function automatic int adv(input int e, input bit c, input int lim);
    if (c) return 0;
    if (e < lim) return e + 1;
    return e;
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      ea1 = 0; ea2 = 0; eb1 = 0; eb2 = 0;
    end else begin
      ea1 = adv(ea1, bus_a.CLRT1, T1S * DIV_A);
      ea2 = adv(ea2, bus_a.CLRT2, T2S * DIV_A);
      eb1 = adv(eb1, bus_b.CLRT1, T1S * DIV_B);
      eb2 = adv(eb2, bus_b.CLRT2, T2S * DIV_B);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("a_t1_model", int'(bus_a.T1DONE), int'(ea1 >= T1S * DIV_A));
    chk("a_t2_model", int'(bus_a.T2DONE), int'(ea2 >= T2S * DIV_A));
    chk("b_t1_model", int'(bus_b.T1DONE), int'(eb1 >= T1S * DIV_B));
    chk("b_t2_model", int'(bus_b.T2DONE), int'(eb2 >= T2S * DIV_B));
`ifdef CARWASH_REMAIN_EN
    chk("a_rem_model", int'(bus_a.REMAIN1), T1S - ea1 / DIV_A);
    chk("b_rem_model", int'(bus_b.REMAIN1), T1S - eb1 / DIV_B);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    bit c1;
    bit c2;
    bit t1;
    bit t2;
    int rem;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bus_a.CLRT1 = 1'b0; bus_a.CLRT2 = 1'b0;
    bus_b.CLRT1 = 1'b0; bus_b.CLRT2 = 1'b0;

    // Directed table for dut_a: inputs and hand-derived outputs after each edge.
    tbl.push_back('{1, 1, 0, 0, 3});
    tbl.push_back('{1, 1, 0, 0, 3});
    tbl.push_back('{1, 1, 0, 0, 3});
    tbl.push_back('{0, 0, 0, 0, 3});  // n=1
    tbl.push_back('{0, 0, 0, 0, 3});
    tbl.push_back('{0, 0, 0, 0, 3});
    tbl.push_back('{0, 0, 0, 0, 2});  // n=4
    tbl.push_back('{0, 0, 0, 0, 2});
    tbl.push_back('{0, 0, 0, 0, 2});
    tbl.push_back('{0, 0, 0, 0, 2});
    tbl.push_back('{0, 0, 0, 1, 1});  // n=8: T2 done
    tbl.push_back('{0, 0, 0, 1, 1});
    tbl.push_back('{0, 0, 0, 1, 1});
    tbl.push_back('{0, 0, 0, 1, 1});
    tbl.push_back('{0, 0, 1, 1, 0});  // n=12: T1 done
    tbl.push_back('{0, 0, 1, 1, 0});
    tbl.push_back('{0, 0, 1, 1, 0});
    tbl.push_back('{0, 0, 1, 1, 0});
    tbl.push_back('{0, 0, 1, 1, 0});
    tbl.push_back('{1, 0, 0, 1, 3});  // clear while done
    tbl.push_back('{0, 0, 0, 1, 3});
    tbl.push_back('{0, 1, 0, 0, 3});
    tbl.push_back('{0, 0, 0, 0, 3});  // T1 at n=3

    // Reset state while clr is held, before any edge.
    #1;
    chk("rst_a_t1", int'(bus_a.T1DONE), 0);
    chk("rst_a_t2", int'(bus_a.T2DONE), 0);
    chk("rst_b_t1", int'(bus_b.T1DONE), 0);
`ifdef CARWASH_REMAIN_EN
    chk("rst_a_rem", int'(bus_a.REMAIN1), T1S);
`endif
    @(posedge clk);
    #1;
    clr = 1'b0;

    foreach (tbl[i]) begin
      bus_a.CLRT1 = tbl[i].c1;
      bus_a.CLRT2 = tbl[i].c2;
      tick();
      chk($sformatf("tbl%0d_t1", i), int'(bus_a.T1DONE), int'(tbl[i].t1));
      chk($sformatf("tbl%0d_t2", i), int'(bus_a.T2DONE), int'(tbl[i].t2));
`ifdef CARWASH_REMAIN_EN
      chk($sformatf("tbl%0d_rem", i), int'(bus_a.REMAIN1), tbl[i].rem);
`endif
    end
    bus_a.CLRT2 = 1'b0;

    // T1 completes after 9 more edges, then holds for 50 cycles.
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("t1_rise", int'(bus_a.T1DONE), int'(i == 9));
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("t1_hold", int'(bus_a.T1DONE), 1);
    end

    // Clear while done, then a clear colliding with the completing edge.
    bus_a.CLRT1 = 1'b1;
    tick();
    chk("clr_while_done", int'(bus_a.T1DONE), 0);
    bus_a.CLRT1 = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk("pre_collide", int'(bus_a.T1DONE), 0);
    end
    bus_a.CLRT1 = 1'b1;
    tick();
    chk("collide", int'(bus_a.T1DONE), 0);
    bus_a.CLRT1 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("retime", int'(bus_a.T1DONE), int'(i == 12));
    end

    // Timer 2 alone: T1 stays done throughout.
    bus_a.CLRT2 = 1'b1;
    tick();
    bus_a.CLRT2 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t2_rise", int'(bus_a.T2DONE), int'(i == 8));
      chk("t1_indep", int'(bus_a.T1DONE), 1);
    end

    // Asynchronous reset with timer 1 at two seconds.
    bus_a.CLRT1 = 1'b1; bus_a.CLRT2 = 1'b1;
    tick();
    bus_a.CLRT1 = 1'b0; bus_a.CLRT2 = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("pre_rst_t2", int'(bus_a.T2DONE), 1);
    clr = 1'b1;
    #1;
    chk("async_t1", int'(bus_a.T1DONE), 0);
    chk("async_t2", int'(bus_a.T2DONE), 0);
    chk("async_b_t1", int'(bus_b.T1DONE), 0);
`ifdef CARWASH_REMAIN_EN
    chk("async_rem", int'(bus_a.REMAIN1), T1S);
`endif
    tick();
    clr = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("post_rst_t1", int'(bus_a.T1DONE), int'(i == 12));
    end

    // TICK_DIV=1 instance: three edges per run.
    bus_b.CLRT1 = 1'b1;
    tick();
    bus_b.CLRT1 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("b_rise", int'(bus_b.T1DONE), int'(i == 3));
    end
    bus_b.CLRT1 = 1'b1;
    tick();
    chk("b_clr_done", int'(bus_b.T1DONE), 0);
    bus_b.CLRT1 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("b_rerise", int'(bus_b.T1DONE), int'(i == 3));
    end

    // Randomized clears and occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      bus_a.CLRT1 = ($urandom_range(0, 19) == 0);
      bus_a.CLRT2 = ($urandom_range(0, 12) == 0);
      bus_b.CLRT1 = ($urandom_range(0, 5) == 0);
      bus_b.CLRT2 = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        clr = 1'b1;
        #1;
        check_model();
        tick();
        clr = 1'b0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
